// File: rtl/rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter
//
// Purpose:
//   Shares one register-file port set (two read ports plus one write port)
//   between two requesters. A round-robin grant is issued in IDLE. The
//   winner's request is latched and presented to the register file for one
//   ISSUE cycle. The registered read data is captured during WAIT. A
//   one-cycle response pulse then goes back to the winner. The accept edge
//   is at cycle t and the response is visible in cycle t+3.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   req_valid[1:0]        per-requester request pending
//   req_ready[1:0]        combinational grant in IDLE (one-hot or zero)
//   req_we[1:0]           per-requester write flag
//   req_ra1/ra2/wa        packed per-requester addresses, [i*ADDR_W +: ADDR_W]
//   req_wd                packed per-requester write data, [i*DATA_W +: DATA_W]
//   rsp_valid[1:0]        one-cycle response pulse for requester i
//   rsp_rd1/rsp_rd2       captured read data, held until the next capture
//   rf_a1/rf_a2/rf_a3     register-file addresses, driven only in ISSUE
//   rf_wd3/rf_we3         register-file write data/enable, driven only in ISSUE
//   rf_rd1/rf_rd2         register-file read data, valid one cycle after address
//   busy                  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module rf_access_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_ra1,
  input  logic [2*ADDR_W-1:0]   req_ra2,
  input  logic [2*ADDR_W-1:0]   req_wa,
  input  logic [2*DATA_W-1:0]   req_wd,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rd1,
  output logic [DATA_W-1:0]     rsp_rd2,
  output logic [ADDR_W-1:0]     rf_a1,
  output logic [ADDR_W-1:0]     rf_a2,
  output logic [ADDR_W-1:0]     rf_a3,
  output logic [DATA_W-1:0]     rf_wd3,
  output logic                  rf_we3,
  input  logic [DATA_W-1:0]     rf_rd1,
  input  logic [DATA_W-1:0]     rf_rd2,
  output logic                  busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              id_q,        id_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] ra1_q,       ra1_d;
  logic [ADDR_W-1:0] ra2_q,       ra2_d;
  logic [ADDR_W-1:0] wa_q,        wa_d;
  logic [DATA_W-1:0] wd_q,        wd_d;
  logic [1:0]        rspValid_q,  rspValid_d;
  logic [DATA_W-1:0] rspRd1_q,    rspRd1_d;
  logic [DATA_W-1:0] rspRd2_q,    rspRd2_d;

  logic winner;
  logic grantNow;
  logic issueActive;

  // Round-robin pick. When both requesters are valid, the one that did not
  // win last time gets the grant. A sole requester always wins.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~lastGrant_q;
      default: winner = 1'b0;
    endcase
  end

  // Readiness is combinational and only meaningful in IDLE. It is gated with
  // rst so that no grant is advertised while reset is held.
  assign grantNow  = (state_q == IDLE) && (|req_valid) && !rst;
  assign req_ready = grantNow ? (winner ? 2'b10 : 2'b01) : 2'b00;

  // Next-state logic. Request fields and last grant are only touched on an
  // accept, so a request withdrawn before acceptance leaves nothing behind.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    id_d        = id_q;
    we_d        = we_q;
    ra1_d       = ra1_q;
    ra2_d       = ra2_q;
    wa_d        = wa_q;
    wd_d        = wd_q;
    rspValid_d  = 2'b00;
    rspRd1_d    = rspRd1_q;
    rspRd2_d    = rspRd2_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = ISSUE;
          lastGrant_d = winner;
          id_d        = winner;
          we_d        = req_we[winner];
          ra1_d       = winner ? req_ra1[ADDR_W +: ADDR_W] : req_ra1[0 +: ADDR_W];
          ra2_d       = winner ? req_ra2[ADDR_W +: ADDR_W] : req_ra2[0 +: ADDR_W];
          wa_d        = winner ? req_wa[ADDR_W +: ADDR_W]  : req_wa[0 +: ADDR_W];
          wd_d        = winner ? req_wd[DATA_W +: DATA_W]  : req_wd[0 +: DATA_W];
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Register-file data for the ISSUE addresses is valid now. The write
        // from ISSUE has not yet been observed, so a same-address read
        // returns the old value.
        state_d    = IDLE;
        rspRd1_d   = rf_rd1;
        rspRd2_d   = rf_rd2;
        rspValid_d = id_q ? 2'b10 : 2'b01;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset favours requester 0 by marking requester 1 as
  // the last winner. Any in-flight request is dropped without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      ra1_q       <= '0;
      ra2_q       <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      rspValid_q  <= 2'b00;
      rspRd1_q    <= '0;
      rspRd2_q    <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      id_q        <= id_d;
      we_q        <= we_d;
      ra1_q       <= ra1_d;
      ra2_q       <= ra2_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      rspValid_q  <= rspValid_d;
      rspRd1_q    <= rspRd1_d;
      rspRd2_q    <= rspRd2_d;
    end
  end

  // The register-file bus is quiet except during ISSUE. Because state_q
  // resets asynchronously, rf_we3 drops the moment rst rises.
  assign issueActive = (state_q == ISSUE);
  assign rf_a1  = issueActive ? ra1_q : '0;
  assign rf_a2  = issueActive ? ra2_q : '0;
  assign rf_a3  = issueActive ? wa_q  : '0;
  assign rf_wd3 = issueActive ? wd_q  : '0;
  assign rf_we3 = issueActive & we_q;

  assign rsp_valid = rspValid_q;
  assign rsp_rd1   = rspRd1_q;
  assign rsp_rd2   = rspRd2_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_access_arbiter
//
// Self-checking bench for rf_access_arbiter. A small register-file model
// with registered reads sits behind the arbiter. At reset, register i holds
// the value i. Directed vectors from a table are run as full transactions.
// Hand-written sequences then cover contention, reset in WAIT, and a
// request withdrawn while busy.
// ---------------------------------------------------------------------------
module tb_rf_access_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic                clk;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_ra1;
  logic [2*ADDR_W-1:0] req_ra2;
  logic [2*ADDR_W-1:0] req_wa;
  logic [2*DATA_W-1:0] req_wd;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rd1;
  logic [DATA_W-1:0]   rsp_rd2;
  logic [ADDR_W-1:0]   rf_a1;
  logic [ADDR_W-1:0]   rf_a2;
  logic [ADDR_W-1:0]   rf_a3;
  logic [DATA_W-1:0]   rf_wd3;
  logic                rf_we3;
  logic [DATA_W-1:0]   rf_rd1;
  logic [DATA_W-1:0]   rf_rd2;
  logic                busy;

  int compared;
  int mismatched;

  logic [DATA_W-1:0] regs [32];

  typedef struct packed {
    logic [1:0]          valid;
    logic [1:0]          we;
    logic [2*ADDR_W-1:0] ra1;
    logic [2*ADDR_W-1:0] ra2;
    logic [2*ADDR_W-1:0] wa;
    logic [2*DATA_W-1:0] wd;
    logic [1:0]          expGrant;
    logic [DATA_W-1:0]   expRd1;
    logic [DATA_W-1:0]   expRd2;
  } vec_t;

  vec_t vecs [7];

  rf_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ra1   (req_ra1),
    .req_ra2   (req_ra2),
    .req_wa    (req_wa),
    .req_wd    (req_wd),
    .rsp_valid (rsp_valid),
    .rsp_rd1   (rsp_rd1),
    .rsp_rd2   (rsp_rd2),
    .rf_a1     (rf_a1),
    .rf_a2     (rf_a2),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_we3    (rf_we3),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .busy      (busy)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file model: synchronous write and registered read. A read and
  // a write to the same register on the same edge return the old value.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (rf_we3) begin
      regs[rf_a3] <= rf_wd3;
    end
    rf_rd1 <= regs[rf_a1];
    rf_rd2 <= regs[rf_a2];
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Runs one full transaction from the table, checking every cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic w;
    logic [ADDR_W-1:0] ea1, ea2, ea3;
    logic [DATA_W-1:0] ewd;
    logic ewe;
    w   = v.expGrant[1];
    ea1 = w ? v.ra1[2*ADDR_W-1:ADDR_W] : v.ra1[ADDR_W-1:0];
    ea2 = w ? v.ra2[2*ADDR_W-1:ADDR_W] : v.ra2[ADDR_W-1:0];
    ea3 = w ? v.wa[2*ADDR_W-1:ADDR_W]  : v.wa[ADDR_W-1:0];
    ewd = w ? v.wd[2*DATA_W-1:DATA_W]  : v.wd[DATA_W-1:0];
    ewe = v.we[w];
    @(posedge clk); #1;
    req_valid = v.valid;
    req_we    = v.we;
    req_ra1   = v.ra1;
    req_ra2   = v.ra2;
    req_wa    = v.wa;
    req_wd    = v.wd;
    @(negedge clk);
    checkOutput($sformatf("v%0d_ready", idx), 32'(req_ready), 32'(v.expGrant));
    checkOutput($sformatf("v%0d_busy_idle", idx), 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput($sformatf("v%0d_rf_a1", idx), 32'(rf_a1), 32'(ea1));
    checkOutput($sformatf("v%0d_rf_a2", idx), 32'(rf_a2), 32'(ea2));
    checkOutput($sformatf("v%0d_rf_a3", idx), 32'(rf_a3), 32'(ea3));
    checkOutput($sformatf("v%0d_rf_wd3", idx), rf_wd3, ewd);
    checkOutput($sformatf("v%0d_rf_we3", idx), 32'(rf_we3), 32'(ewe));
    checkOutput($sformatf("v%0d_busy_issue", idx), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d_ready_busy", idx), 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("v%0d_we3_wait", idx), 32'(rf_we3), 32'd0);
    checkOutput($sformatf("v%0d_a1_wait", idx), 32'(rf_a1), 32'd0);
    checkOutput($sformatf("v%0d_rsp_early", idx), 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'(v.expGrant));
    checkOutput($sformatf("v%0d_rsp_rd1", idx), rsp_rd1, v.expRd1);
    checkOutput($sformatf("v%0d_rsp_rd2", idx), rsp_rd2, v.expRd2);
    checkOutput($sformatf("v%0d_busy_done", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Directed transactions; field packing is {requester1, requester0}.
    vecs[0] = '{valid: 2'b01, we: 2'b00, ra1: {5'd0, 5'd3}, ra2: {5'd0, 5'd7},
                wa: 10'd0, wd: 64'd0, expGrant: 2'b01, expRd1: 32'd3, expRd2: 32'd7};
    vecs[1] = '{valid: 2'b01, we: 2'b01, ra1: {5'd0, 5'd5}, ra2: {5'd0, 5'd2},
                wa: {5'd0, 5'd5}, wd: {32'd0, 32'hDEADBEEF}, expGrant: 2'b01,
                expRd1: 32'd5, expRd2: 32'd2};
    vecs[2] = '{valid: 2'b10, we: 2'b00, ra1: {5'd5, 5'd0}, ra2: {5'd0, 5'd0},
                wa: 10'd0, wd: 64'd0, expGrant: 2'b10, expRd1: 32'hDEADBEEF, expRd2: 32'd0};
    vecs[3] = '{valid: 2'b11, we: 2'b00, ra1: {5'd9, 5'd1}, ra2: {5'd10, 5'd4},
                wa: 10'd0, wd: 64'd0, expGrant: 2'b01, expRd1: 32'd1, expRd2: 32'd4};
    vecs[4] = '{valid: 2'b11, we: 2'b00, ra1: {5'd9, 5'd1}, ra2: {5'd10, 5'd4},
                wa: 10'd0, wd: 64'd0, expGrant: 2'b10, expRd1: 32'd9, expRd2: 32'd10};
    vecs[5] = '{valid: 2'b10, we: 2'b10, ra1: {5'd31, 5'd0}, ra2: {5'd30, 5'd0},
                wa: {5'd31, 5'd0}, wd: {32'h12345678, 32'd0}, expGrant: 2'b10,
                expRd1: 32'd31, expRd2: 32'd30};
    vecs[6] = '{valid: 2'b01, we: 2'b00, ra1: {5'd0, 5'd31}, ra2: {5'd0, 5'd5},
                wa: 10'd0, wd: 64'd0, expGrant: 2'b01, expRd1: 32'h12345678,
                expRd2: 32'hDEADBEEF};

    rst       = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_ra1   = '0;
    req_ra2   = '0;
    req_wa    = '0;
    req_wd    = '0;

    // Reset state, checked before any clock edge with requests pending.
    #1 rst = 1'b1;
    req_valid = 2'b11;
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rd1", rsp_rd1, 32'd0);
    checkOutput("rst_rsp_rd2", rsp_rd2, 32'd0);
    checkOutput("rst_we3", 32'(rf_we3), 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Contention: both requesters valid continuously from reset.
    $display("[TB] contention sequence");
    @(posedge clk); #1;
    rst       = 1'b1;
    req_we    = 2'b00;
    req_ra1   = {5'd11, 5'd1};
    req_ra2   = {5'd12, 5'd2};
    req_wa    = '0;
    req_wd    = '0;
    req_valid = 2'b11;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      logic [1:0] expReady;
      logic [1:0] expRsp;
      @(negedge clk);
      expReady = 2'b00;
      expRsp   = 2'b00;
      if (c % 3 == 0) begin
        expReady = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
        if (c >= 3) expRsp = (((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10;
      end
      checkOutput($sformatf("cont_ready_c%0d", c), 32'(req_ready), 32'(expReady));
      checkOutput($sformatf("cont_rsp_c%0d", c), 32'(rsp_valid), 32'(expRsp));
      if (expRsp != 2'b00)
        checkOutput($sformatf("cont_rd1_c%0d", c), rsp_rd1, (expRsp == 2'b01) ? 32'd1 : 32'd11);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitIdle();

    // Reset during WAIT. The request in flight went to requester 0, so only
    // the reset can make requester 0 win the following contention.
    $display("[TB] reset-in-wait sequence");
    @(posedge clk); #1;
    req_ra1   = {5'd11, 5'd3};
    req_ra2   = {5'd12, 5'd8};
    req_valid = 2'b01;
    @(negedge clk);
    checkOutput("rw_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rw_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rw_busy_rst", 32'(busy), 32'd0);
    checkOutput("rw_we3_rst", 32'(rf_we3), 32'd0);
    req_valid = 2'b11;
    #1;
    checkOutput("rw_ready_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("rw_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rw_rsp_after", 32'(rsp_valid), 32'd0);
    checkOutput("rw_grant0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("rw_rf_a1", 32'(rf_a1), 32'd3);
    @(negedge clk);
    checkOutput("rw_rsp_t2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("rw_rsp_t3", 32'(rsp_valid), 32'd1);
    checkOutput("rw_rd1", rsp_rd1, 32'd3);
    checkOutput("rw_rd2", rsp_rd2, 32'd8);

    // Withdrawn request: requester 1 pulses valid for one cycle while busy.
    $display("[TB] withdrawn-request sequence");
    @(posedge clk); #1;
    req_ra1   = {5'd20, 5'd4};
    req_ra2   = {5'd21, 5'd6};
    req_wa    = {5'd20, 5'd0};
    req_wd    = {32'hCAFEF00D, 32'd0};
    req_valid = 2'b01;
    @(negedge clk);
    checkOutput("wd_ready0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    req_we    = 2'b10;
    @(negedge clk);
    checkOutput("wd_ready_pulse", 32'(req_ready), 32'd0);
    checkOutput("wd_we3_issue", 32'(rf_we3), 32'd0);
    checkOutput("wd_a1_issue", 32'(rf_a1), 32'd4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    @(negedge clk);
    checkOutput("wd_we3_wait", 32'(rf_we3), 32'd0);
    @(negedge clk);
    checkOutput("wd_rsp", 32'(rsp_valid), 32'd1);
    checkOutput("wd_rd1", rsp_rd1, 32'd4);
    @(negedge clk);
    checkOutput("wd_idle_busy", 32'(busy), 32'd0);
    checkOutput("wd_idle_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("wd_idle_a3", 32'(rf_a3), 32'd0);
    checkOutput("wd_idle_we3", 32'(rf_we3), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("wd_lastgrant_kept", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitIdle();
    checkOutput("wd_reg20_unwritten", regs[20], 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
